tt_um_serial_adder: RTL

TT_UM_SERIAL_ADDER -- requirements
Module: tt_um_serial_adder

---
 rtl/serial_adder_pkg.sv | 27 ++
 rtl/serial_adder_fa_bit.sv | 15 +
 rtl/tt_um_serial_adder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM states, default
// operand width and the bit positions used on the uio bus.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int UIO_LOAD_A = 0;
   localparam int UIO_LOAD_B = 1;
   localparam int UIO_START  = 2;
   localparam int UIO_BUSY   = 3;
   localparam int UIO_DONE   = 4;
   localparam int UIO_CARRY  = 5;

   localparam logic [7:0] UIO_OE_MASK = 8'b0011_1000;

   // A one-bit operand still needs a one-bit counter.
   function automatic int cnt_bits(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Single-bit full adder used by the serial datapath once per RUN cycle.
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   always_comb begin
      sum  = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/tt_um_serial_adder.sv
// Bit-serial adder: operands are loaded over ui_in, added LSB-first one bit
// per clock, and the sum plus final carry are latched when the last bit is done.
module tt_um_serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int CNT_W = cnt_bits(WIDTH);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_shifted;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] operand;
   logic [CNT_W-1:0] count;
   logic             carry;
   logic             carry_out;
   logic             start_q;

   logic             load_a;
   logic             load_b;
   logic             start;
   logic             any_load;
   logic             start_edge;
   logic             load_en;
   logic             start_go;
   logic             step;
   logic             last_bit;
   logic             sum_bit;
   logic             carry_next;
   logic             busy;
   logic             done;
   logic             unused_inputs;

   assign load_a = uio_in[UIO_LOAD_A];
   assign load_b = uio_in[UIO_LOAD_B];
   assign start  = uio_in[UIO_START];

   assign unused_inputs = &{1'b0, ena, uio_in[7:3]};

   // Adapt the fixed 8-bit input bus to the configured operand width.
   generate
      if (WIDTH == 8) begin : g_operand_eq
         assign operand = ui_in;
      end else if (WIDTH > 8) begin : g_operand_wide
         assign operand = {{(WIDTH-8){1'b0}}, ui_in};
      end else begin : g_operand_narrow
         assign operand = ui_in[WIDTH-1:0];
      end
   endgenerate

   fa_bit u_fa_bit (
      .a    (op_a[0]),
      .b    (op_b[0]),
      .cin  (carry),
      .sum  (sum_bit),
      .cout (carry_next)
   );

   assign work_shifted = {sum_bit, work[WIDTH-1:1]};

   // All architectural state lives here; control decisions come from the
   // next-state logic so this block only applies them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         work      <= '0;
         result    <= '0;
         count     <= '0;
         carry     <= 1'b0;
         carry_out <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         state   <= next_state;
         start_q <= start;
         if (load_en) begin
            if (load_a) begin
               op_a <= operand;
            end
            if (load_b) begin
               op_b <= operand;
            end
         end else if (start_go) begin
            carry <= 1'b0;
            count <= '0;
            work  <= '0;
         end else if (step) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            work  <= work_shifted;
            carry <= carry_next;
            count <= count + 1'b1;
            if (last_bit) begin
               result    <= work_shifted;
               carry_out <= carry_next;
            end
         end
      end
   end

   // A start edge that coincides with a load is swallowed: start_q still
   // records it, so holding start high afterwards does not retrigger.
   always_comb begin
      next_state = state;
      any_load   = load_a | load_b;
      start_edge = start & ~start_q;
      load_en    = 1'b0;
      start_go   = 1'b0;
      step       = 1'b0;
      last_bit   = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            load_en  = any_load;
            start_go = start_edge & ~any_load;
            if (start_go) begin
               next_state = RUN;
            end
         end
         RUN: begin
            step     = 1'b1;
            last_bit = (count == CNT_W'(WIDTH - 1));
            if (last_bit) begin
               next_state = DONE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_comb begin
      busy               = (state == RUN);
      done               = (state == DONE);
      uio_out            = '0;
      uio_out[UIO_BUSY]  = busy;
      uio_out[UIO_DONE]  = done;
      uio_out[UIO_CARRY] = carry_out;
   end

   assign uio_oe = UIO_OE_MASK;

   generate
      if (WIDTH == 8) begin : g_out_eq
         assign uo_out = result;
      end else if (WIDTH > 8) begin : g_out_wide
         assign uo_out = result[7:0];
      end else begin : g_out_narrow
         assign uo_out = {{(8-WIDTH){1'b0}}, result};
      end
   endgenerate

endmodule
